trace_emitter: RTL

- Synthesizable commit-trace producer that sits beside mod_CPU and taps WB and MEM stage signals.
- Each cycle it encodes REG, LOAD, STORE and HALT events into records and buffers them in a FIFO.
- It serializes each record as 16-bit words on a valid/ready stream for an off-chip or bench-side trace consumer.
- Bench and hardware therefore share one trace format instead of relying on hierarchical probes.

---
 rtl/trace_emitter.sv | 108 ++++++++++
 1 files changed

// File: rtl/trace_emitter.sv
// trace_emitter: encodes commit events into records, buffers them and streams them as 16-bit words
module trace_emitter #(
  parameter int DEPTH = 8,
  parameter int DROPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_regwrite,
  input  logic [3:0]       wb_reg,
  input  logic [15:0]      wb_data,
  input  logic             mem_en,
  input  logic             mem_we,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             overflow,
  output logic [DROPW-1:0] drop_count,
  output logic             done
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;
  logic [37:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [15:0] r_cyc, r_inst, r_hold;
  logic [DROPW-1:0] r_drop;
  logic r_halted, r_overflow, r_done;
  state_t r_state, w_state_n;
  logic [1:0] w_need, w_idx;
  logic [AW:0] w_occ, w_free, w_p_mem, w_p_halt, w_wptr_n, w_rptr_n;
  logic w_ev, w_fit, w_push, w_drop, w_inc, w_halted_n;
  logic [15:0] w_inst_n, w_word;
  logic [37:0] w_e_reg, w_e_mem, w_e_halt, w_head;
  logic w_empty, w_fire, w_lastw, w_pop;
  assign w_need = {1'b0, wb_regwrite} + {1'b0, mem_en} + {1'b0, halt};
  assign w_occ = r_wptr - r_rptr;
  assign w_free = (AW+1)'(DEPTH) - w_occ;
  assign w_ev = ~r_halted & (w_need != 2'd0);
  assign w_fit = (AW+1)'(w_need) <= w_free;
  assign w_push = w_ev & w_fit;
  assign w_drop = w_ev & ~w_fit;
  assign w_inc = halt | wb_regwrite | (mem_en & mem_we);
  assign w_inst_n = r_inst + 16'(w_inc);
  assign w_e_reg = {2'd0, wb_reg, wb_data, 16'h0000};
  assign w_e_mem = {mem_we ? 2'd2 : 2'd1, 4'h0, mem_addr, mem_we ? mem_wdata : mem_rdata};
  assign w_e_halt = {2'd3, 4'h0, r_cyc, w_inst_n};
  assign w_p_mem = r_wptr + (AW+1)'(wb_regwrite);
  assign w_p_halt = w_p_mem + (AW+1)'(mem_en);
  assign w_wptr_n = r_wptr + (w_push ? (AW+1)'(w_need) : '0);
  assign w_halted_n = r_halted | (w_push & halt);
  assign w_head = r_mem[r_rptr[AW-1:0]];
  assign w_empty = r_wptr == r_rptr;
  assign w_idx = r_state == W1 ? 2'd1 : r_state == W2 ? 2'd2 : 2'd0;
  assign w_word = w_idx == 2'd0 ? {w_head[37:36], 10'b0, w_head[35:32]} :
                  w_idx == 2'd1 ? w_head[31:16] : w_head[15:0];
  assign w_lastw = w_head[37:36] == 2'd0 ? w_idx == 2'd1 : w_idx == 2'd2;
  assign w_fire = ~w_empty & out_ready;
  assign w_pop = w_fire & w_lastw;
  assign w_rptr_n = r_rptr + (AW+1)'(w_pop);
  assign out_valid = ~w_empty;
  assign out_data = w_empty ? r_hold : w_word;
  assign out_last = ~w_empty & w_lastw;
  assign overflow = r_overflow;
  assign drop_count = r_drop;
  assign done = r_done;
  // Record storage: a cycle's records land in consecutive slots in REG, MEM, HALT order
  always_ff @(posedge clk) begin
    if (w_push & wb_regwrite) r_mem[r_wptr[AW-1:0]] <= w_e_reg;
    if (w_push & mem_en) r_mem[w_p_mem[AW-1:0]] <= w_e_mem;
    if (w_push & halt) r_mem[w_p_halt[AW-1:0]] <= w_e_halt;
  end
  // Serializer next state: hold on backpressure, chain straight into the next record after the last word
  always_comb begin
    w_state_n = r_state;
    if (!w_fire) w_state_n = (r_state == IDLE && !w_empty) ? W0 : r_state;
    else w_state_n = w_lastw ? ((w_wptr_n != w_rptr_n) ? W0 : IDLE) : (w_idx == 2'd0 ? W1 : W2);
  end
  // Pointers, counters, drop accounting and the registered done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cyc <= '0;
      r_inst <= '0;
      r_hold <= '0;
      r_drop <= '0;
      r_halted <= 1'b0;
      r_overflow <= 1'b0;
      r_done <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_wptr <= w_wptr_n;
      r_rptr <= w_rptr_n;
      r_cyc <= r_cyc + 16'd1;
      r_inst <= w_inst_n;
      r_hold <= out_data;
      if (w_drop && !(&r_drop)) r_drop <= r_drop + DROPW'(1);
      r_overflow <= r_overflow | w_drop;
      r_halted <= w_halted_n;
      r_done <= w_halted_n & (w_wptr_n == w_rptr_n) & (w_state_n == IDLE);
      r_state <= w_state_n;
    end
  end
endmodule
